data_mem_responder: RTL and testbench

Data-memory responder for the single-cycle RISC-V core: the memory end of the datapath's dAddress/dWriteData/dReadData interface. Accepts one load or store request at a time from the core's MemRead/MemWrite strobes, inserts a programmable number of wait states, and answers with a one-cycle completion pulse plus registered read data. It replaces the zero-latency behavioural memory so the core's loadPC stall logic can be exercised against a real handshake.

---
 rtl/data_mem_responder_if.sv | 31 +++
 rtl/data_mem_responder.sv | 136 +++++++++++++
 tb/tb_data_mem_responder.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - core <-> data memory request/response bundle
// dWStrb exists only when DMEM_BYTE_EN is defined.
interface data_mem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] dAddress;
  logic [31:0] dWriteData;
`ifdef DMEM_BYTE_EN
  logic [3:0]  dWStrb;
`endif
  logic [31:0] dReadData;
  logic        memReady;
  logic        busy;
  logic        err;

  modport master (
    output MemRead, MemWrite, dAddress, dWriteData,
`ifdef DMEM_BYTE_EN
    output dWStrb,
`endif
    input  dReadData, memReady, busy, err
  );

  modport slave (
    input  MemRead, MemWrite, dAddress, dWriteData,
`ifdef DMEM_BYTE_EN
    input  dWStrb,
`endif
    output dReadData, memReady, busy, err
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-state data memory answering one load/store at a time
// Optional byte-strobed stores: define DMEM_BYTE_EN.
module data_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_WAIT    = 2'd1;
  localparam logic [1:0]  S_RESP    = 2'd2;
  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]  state;
  logic [3:0]  count;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        rd_q;
  logic        wr_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic        idle;
  logic        req;
  logic        commit;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        cur_rd;
  logic        cur_wr;
  logic [31:0] cur_off;
  logic        cur_bad;
  logic [IDX_W-1:0] cur_idx;
  logic [3:0]  cur_strb;

`ifdef DMEM_BYTE_EN
  logic [3:0]  strb_q;
  assign cur_strb = idle ? bus.dWStrb : strb_q;
`else
  assign cur_strb = 4'hF;
`endif

  assign idle = (state == S_IDLE);
  assign req  = bus.MemRead | bus.MemWrite;

  // With zero wait states the access commits on the sampling edge itself,
  // so the live request is used instead of the not-yet-latched copy.
  always_comb begin
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_rd    = rd_q;
    cur_wr    = wr_q;
    if (idle) begin
      cur_addr  = bus.dAddress;
      cur_wdata = bus.dWriteData;
      cur_rd    = bus.MemRead;
      cur_wr    = bus.MemWrite;
    end
  end

  // Addresses below BASE_ADDR wrap to a huge offset and fail the span test.
  assign cur_off = cur_addr - BASE_ADDR;
  assign cur_idx = cur_off[IDX_W+1:2];
  assign cur_bad = (cur_off >= SPAN) || (cur_addr[1:0] != 2'b00) || (cur_rd && cur_wr);

  assign commit = (idle && req && (WAIT_CYCLES == 0)) ||
                  ((state == S_WAIT) && (count == 4'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      count   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
`ifdef DMEM_BYTE_EN
      strb_q  <= 4'h0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            addr_q  <= bus.dAddress;
            wdata_q <= bus.dWriteData;
            rd_q    <= bus.MemRead;
            wr_q    <= bus.MemWrite;
`ifdef DMEM_BYTE_EN
            strb_q  <= bus.dWStrb;
`endif
            count   <= WAIT_INIT;
            state   <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Response registers; stores leave dReadData alone, errored loads clear it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else if (commit) begin
      err_q <= cur_bad;
      if (cur_rd) rdata_q <= cur_bad ? 32'h0 : mem[cur_idx];
    end
  end

  // Array contents survive reset; state is forced IDLE so no commit occurs.
  always_ff @(posedge clk) begin
    if (commit && cur_wr && !cur_bad) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_strb[b]) mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
      end
    end
  end

  assign bus.memReady  = (state == S_RESP);
  assign bus.busy      = !idle;
  assign bus.err       = (state == S_RESP) && err_q;
  assign bus.dReadData = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - vector table, hand sequences and random ops vs. word-array model
module tb_data_mem_responder;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 256;
  localparam int          WAITS = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if bus();

  data_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rdata = 32'h0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        exp_err;
    logic        chk_data;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: flat word array indexed by byte offset / 4.
  task automatic model_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] strb,
                              output logic exp_err);
    longint off;
    int idx;
    off = (addr >= BASE) ? longint'(addr) - longint'(BASE) : -1;
    exp_err = (off < 0) || (off >= 4 * DEPTH) || (addr % 4 != 0) || (rd && wr);
    idx = exp_err ? 0 : int'(off / 4);
    if (exp_err) begin
      if (rd) model_rdata = 32'h0;
    end else if (wr) begin
      for (int b = 0; b < 4; b++) begin
`ifdef DMEM_BYTE_EN
        if (strb[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
`else
        model_mem[idx][8*b +: 8] = data[8*b +: 8];
`endif
      end
    end else if (rd) begin
      model_rdata = model_mem[idx];
    end
  endtask

  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb,
                           output logic got_err, output logic [31:0] got_rdata,
                           output int lat, output int busy_cnt);
    @(negedge clk);
    bus.MemRead    = rd;
    bus.MemWrite   = wr;
    bus.dAddress   = addr;
    bus.dWriteData = data;
`ifdef DMEM_BYTE_EN
    bus.dWStrb     = strb;
`endif
    lat = 0;
    busy_cnt = 0;
    got_err = 1'b0;
    got_rdata = 32'h0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy) busy_cnt++;
      if (bus.memReady) break;
    end
    if (!bus.memReady) begin
      tests++;
      fails++;
      $display("FAIL timeout: no memReady within %0d cycles", lat);
    end
    got_err   = bus.err;
    got_rdata = bus.dReadData;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    @(posedge clk);
    #1;
    check("ready_one_cycle", {31'b0, bus.memReady}, 32'h0);
    check("busy_after_resp", {31'b0, bus.busy}, 32'h0);
  endtask

  logic        e_err, g_err;
  logic [31:0] g_rd;
  int          g_lat, g_busy;

  initial begin
    bus.MemRead = 1'b0;
    bus.MemWrite = 1'b0;
    bus.dAddress = 32'h0;
    bus.dWriteData = 32'h0;
`ifdef DMEM_BYTE_EN
    bus.dWStrb = 4'h0;
`endif

    vecs.push_back('{1'b0, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h1001_0004, 32'h0,         4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{1'b1, 1'b0, 32'h1001_0006, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h1001_0004, 32'h0,         4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{1'b1, 1'b0, 32'h1001_0400, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h1000_FFFC, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h1001_0000, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 32'h1001_0000, 32'h5555_AAAA, 4'hF, 1'b1, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h1001_0000, 32'h0,         4'hF, 1'b0, 1'b1, 32'h1234_5678});
    vecs.push_back('{1'b0, 1'b1, 32'h1001_03FC, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h1001_03FC, 32'h0,         4'hF, 1'b0, 1'b1, 32'hCAFE_F00D});
    vecs.push_back('{1'b0, 1'b1, 32'h1001_0400, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h1001_0010, 32'h1122_3344, 4'hF, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 32'h1001_0010, 32'hAABB_CCDD, 4'b0101, 1'b0, 1'b0, 32'h0});
`ifdef DMEM_BYTE_EN
    vecs.push_back('{1'b1, 1'b0, 32'h1001_0010, 32'h0, 4'hF, 1'b0, 1'b1, 32'h11BB_33DD});
    vecs.push_back('{1'b0, 1'b1, 32'h1001_0010, 32'h9999_9999, 4'b0000, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'h1001_0010, 32'h0, 4'hF, 1'b0, 1'b1, 32'h11BB_33DD});
`else
    vecs.push_back('{1'b1, 1'b0, 32'h1001_0010, 32'h0, 4'hF, 1'b0, 1'b1, 32'hAABB_CCDD});
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rst_memReady", {31'b0, bus.memReady}, 32'h0);
    check("rst_busy", {31'b0, bus.busy}, 32'h0);
    check("rst_err", {31'b0, bus.err}, 32'h0);
    check("rst_dReadData", bus.dReadData, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Fill the array so every later load has a known expectation.
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] v;
      v = $urandom;
      model_access(1'b0, 1'b1, BASE + 32'(4 * i), v, 4'hF, e_err);
      do_access(1'b0, 1'b1, BASE + 32'(4 * i), v, 4'hF, g_err, g_rd, g_lat, g_busy);
    end

    foreach (vecs[i]) begin
      model_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, e_err);
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                g_err, g_rd, g_lat, g_busy);
      check($sformatf("vec%0d_err", i), {31'b0, g_err}, {31'b0, vecs[i].exp_err});
      check($sformatf("vec%0d_latency", i), g_lat, WAITS + 1);
      check($sformatf("vec%0d_busy_cycles", i), g_busy, WAITS + 1);
      if (vecs[i].chk_data) check($sformatf("vec%0d_rdata", i), g_rd, vecs[i].exp_rdata);
    end

    // Load data must stay put once the request is gone.
    do_access(1'b1, 1'b0, 32'h1001_0004, 32'h0, 4'hF, g_err, g_rd, g_lat, g_busy);
    model_access(1'b1, 1'b0, 32'h1001_0004, 32'h0, 4'hF, e_err);
    repeat (4) @(posedge clk);
    #1;
    check("rdata_held", bus.dReadData, 32'hDEAD_BEEF);

    // Reset during WAIT of a store: outputs clear immediately, word untouched.
    @(negedge clk);
    bus.MemWrite = 1'b1;
    bus.dAddress = 32'h1001_0008;
    bus.dWriteData = 32'h0BAD_0BAD;
`ifdef DMEM_BYTE_EN
    bus.dWStrb = 4'hF;
`endif
    @(posedge clk);
    #1;
    check("mid_busy_before_rst", {31'b0, bus.busy}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, bus.busy}, 32'h0);
    check("mid_rst_ready", {31'b0, bus.memReady}, 32'h0);
    check("mid_rst_rdata", bus.dReadData, 32'h0);
    bus.MemWrite = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_rdata = 32'h0;
    model_access(1'b1, 1'b0, 32'h1001_0008, 32'h0, 4'hF, e_err);
    do_access(1'b1, 1'b0, 32'h1001_0008, 32'h0, 4'hF, g_err, g_rd, g_lat, g_busy);
    check("mid_rst_old_value", g_rd, model_rdata);
    check("mid_rst_err", {31'b0, g_err}, 32'h0);

    for (int n = 0; n < 300; n++) begin
      logic rd, wr;
      logic [31:0] addr, data;
      logic [3:0] strb;
      int kind;
      kind = $urandom_range(0, 19);
      rd = $urandom_range(0, 1);
      wr = !rd;
      if (kind == 0) begin rd = 1'b1; wr = 1'b1; end
      addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      if (kind == 1) addr = addr + 32'($urandom_range(1, 3));
      if (kind == 2) addr = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 1000));
      if (kind == 3) addr = BASE - 32'(4 * $urandom_range(1, 1000));
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      model_access(rd, wr, addr, data, strb, e_err);
      do_access(rd, wr, addr, data, strb, g_err, g_rd, g_lat, g_busy);
      check($sformatf("rand%0d_err", n), {31'b0, g_err}, {31'b0, e_err});
      check($sformatf("rand%0d_rdata", n), g_rd, model_rdata);
      check($sformatf("rand%0d_latency", n), g_lat, WAITS + 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
